mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and parameter defaults for the memory port arbiter.
// The latency counter is 3 bits wide because MEM_LATENCY is at most 7.
// The starvation counter is 4 bits wide because STARVE_LIMIT is at most 15.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_MEM_LATENCY  = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive fetch losses.
// o_at_limit tells the arbiter that fetch must win the next arbitration.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;

  // Clear takes priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single fixed-latency memory port.
// Data has priority over fetch; fetch is forced to win after STARVE_LIMIT losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic                  grant_id,
  output state_t                dbg_state
);

  // Handshake: a requester raises req with its command stable and keeps it there
  // until the one-cycle ack. Requests are sampled only in IDLE. Once a request is
  // granted, the transaction always completes, even if req drops mid-way.

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LATENCY);

  state_t                  r_state;
  state_t                  w_next;
  logic [LAT_CNT_W-1:0]    r_lat_cnt;
  logic                    r_grant;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_if_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;

  logic w_any_req;
  logic w_at_limit;
  logic w_fetch_wins;
  logic w_arb;
  logic w_lat_done;
  logic w_access;
  logic w_starve_clr;
  logic w_starve_inc;

  assign w_any_req    = if_req | d_req;
  assign w_fetch_wins = if_req & (~d_req | w_at_limit);
  assign w_arb        = (r_state == ST_IDLE) & w_any_req;
  assign w_lat_done   = (r_lat_cnt == LAT_LAST);
  assign w_access     = (r_state == ST_ACCESS);

  // The starvation count only changes in IDLE, so requests seen during ACCESS or RESP are ignored.
  assign w_starve_clr = (r_state == ST_IDLE) & (~if_req | w_fetch_wins);
  assign w_starve_inc = w_arb & if_req & ~w_fetch_wins;

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_starve_clr),
    .i_inc      (w_starve_inc),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
      ST_ACCESS: if (w_lat_done) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // A fetch is always a read, so its write enable and write data are latched as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt  <= '0;
      r_grant    <= GRANT_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_arb) begin
      r_lat_cnt <= '0;
      r_grant   <= w_fetch_wins ? GRANT_IF : GRANT_D;
      r_we      <= w_fetch_wins ? 1'b0 : d_we;
      r_addr    <= w_fetch_wins ? if_addr : d_addr;
      r_wdata   <= w_fetch_wins ? '0 : d_wdata;
    end else if (w_access) begin
      if (!w_lat_done) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end else if (!r_we) begin
        if (r_grant == GRANT_IF) r_if_rdata <= m_rdata;
        else                     r_d_rdata  <= m_rdata;
      end
    end
  end

  // The memory-side outputs are valid only during ACCESS; m_en pulses on the first ACCESS cycle.
  assign m_en      = w_access & (r_lat_cnt == '0);
  assign m_we      = w_access & r_we;
  assign m_addr    = w_access ? r_addr : '0;
  assign m_wdata   = w_access ? r_wdata : '0;
  assign if_ack    = (r_state == ST_RESP) & (r_grant == GRANT_IF);
  assign d_ack     = (r_state == ST_RESP) & (r_grant == GRANT_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at its default parameters (MEM_LATENCY=2, STARVE_LIMIT=4).
// Cycles are stepped one at a time; every check is an immediate assertion.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;
  logic        grant_id;
  state_t      dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [0:0] exp_q[$];

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .m_en      (m_en),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ack"},   32'(if_ack),   32'd0);
    chk({tag, "_d_ack"},    32'(d_ack),    32'd0);
    chk({tag, "_m_en"},     32'(m_en),     32'd0);
    chk({tag, "_m_we"},     32'(m_we),     32'd0);
    chk({tag, "_m_addr"},   m_addr,        32'd0);
    chk({tag, "_m_wdata"},  m_wdata,       32'd0);
    chk({tag, "_if_rdata"}, if_rdata,      32'd0);
    chk({tag, "_d_rdata"},  d_rdata,       32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_state"},    32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int last_ack;
    logic [0:0] got;
    logic [0:0] exp_g;

    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = 32'hA5A5A5A5;
    #1;
    chk_all_zero("por");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Fetch read of 0x10; memory returns 0xE3A00005 at T+2.
    if_req  = 1'b1;
    if_addr = 32'h00000010;
    tick();  // T
    chk("f_T_m_en",    32'(m_en), 32'd1);
    chk("f_T_m_we",    32'(m_we), 32'd0);
    chk("f_T_m_addr",  m_addr, 32'h10);
    chk("f_T_busy",    32'(busy), 32'd1);
    chk("f_T_grant",   32'(grant_id), 32'(GRANT_IF));
    tick();  // T+1
    chk("f_T1_m_en",   32'(m_en), 32'd0);
    chk("f_T1_m_addr", m_addr, 32'h10);
    chk("f_T1_ack",    32'(if_ack), 32'd0);
    tick();  // T+2
    m_rdata = 32'hE3A00005;
    chk("f_T2_m_en",   32'(m_en), 32'd0);
    chk("f_T2_ack",    32'(if_ack), 32'd0);
    tick();  // T+3
    m_rdata = 32'h0BAD0BAD;
    chk("f_ack",       32'(if_ack), 32'd1);
    chk("f_no_dack",   32'(d_ack), 32'd0);
    chk("f_rdata",     if_rdata, 32'hE3A00005);
    chk("f_d_rdata",   d_rdata, 32'd0);
    chk("f_resp_addr", m_addr, 32'd0);
    if_req = 1'b0;
    tick();
    chk("f_idle_ack",  32'(if_ack), 32'd0);
    chk("f_idle_busy", 32'(busy), 32'd0);

    // Data write of 0x7 to 0x64.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h64;
    d_wdata = 32'h7;
    tick();  // T
    chk("w_T_m_en",    32'(m_en), 32'd1);
    chk("w_T_m_we",    32'(m_we), 32'd1);
    chk("w_T_m_addr",  m_addr, 32'h64);
    chk("w_T_m_wdata", m_wdata, 32'h7);
    chk("w_T_grant",   32'(grant_id), 32'(GRANT_D));
    tick();  // T+1
    m_rdata = 32'h55555555;
    chk("w_T1_m_en",   32'(m_en), 32'd0);
    chk("w_T1_m_we",   32'(m_we), 32'd1);
    chk("w_T1_m_wdata", m_wdata, 32'h7);
    tick();  // T+2
    chk("w_T2_m_addr", m_addr, 32'h64);
    chk("w_T2_m_we",   32'(m_we), 32'd1);
    tick();  // T+3
    chk("w_ack",       32'(d_ack), 32'd1);
    chk("w_no_ifack",  32'(if_ack), 32'd0);
    chk("w_d_rdata",   d_rdata, 32'd0);
    chk("w_if_rdata",  if_rdata, 32'hE3A00005);
    chk("w_resp_m_we", 32'(m_we), 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk("w_idle_busy", 32'(busy), 32'd0);

    // Both requesters held: data wins four times, then fetch once.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(GRANT_D);
      exp_q.push_back(GRANT_IF);
    end
    if_req   = 1'b1;
    if_addr  = 32'h100;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 32'h200;
    m_rdata  = 32'h11112222;
    last_ack = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("st_both_acks", 32'(if_ack & d_ack), 32'd0);
      if (if_ack | d_ack) begin
        got = d_ack ? GRANT_D : GRANT_IF;
        if (exp_q.size() == 0) begin
          chk("st_extra_ack", 32'(got), 32'd2);
        end else begin
          exp_g = exp_q.pop_front();
          chk("st_grant_seq", 32'(got), 32'(exp_g));
          chk("st_grant_id",  32'(grant_id), 32'(exp_g));
        end
        if (last_ack >= 0) chk("st_ack_spacing", 32'(i - last_ack), 32'd5);
        last_ack = i;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("st_acks_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk("st_idle_busy", 32'(busy), 32'd0);

    // Data read aborted by reset at T+1, then a clean fetch.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h80;
    m_rdata = 32'hCAFEF00D;
    tick();  // T
    chk("ra_T_m_en", 32'(m_en), 32'd1);
    tick();  // T+1
    reset = 1'b0;
    #1;
    chk_all_zero("ra_rst");
    d_req = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ra_no_dack", 32'(d_ack), 32'd0);
      chk("ra_busy",    32'(busy), 32'd0);
    end
    if_req  = 1'b1;
    if_addr = 32'h20;
    m_rdata = 32'h12345678;
    tick();  // T
    chk("ra_f_m_en",  32'(m_en), 32'd1);
    chk("ra_f_addr",  m_addr, 32'h20);
    tick();
    tick();
    tick();  // T+3
    chk("ra_f_ack",   32'(if_ack), 32'd1);
    chk("ra_f_rdata", if_rdata, 32'h12345678);
    chk("ra_f_drd",   d_rdata, 32'd0);
    if_req = 1'b0;
    tick();

    // Data read whose request drops at T+1 still completes.
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h90;
    m_rdata = 32'h0;
    tick();  // T
    chk("dr_T_m_en", 32'(m_en), 32'd1);
    tick();  // T+1
    d_req   = 1'b0;
    m_rdata = 32'hDEADBEEF;
    tick();  // T+2
    chk("dr_T2_busy", 32'(busy), 32'd1);
    tick();  // T+3
    m_rdata = 32'h0;
    chk("dr_ack",     32'(d_ack), 32'd1);
    chk("dr_rdata",   d_rdata, 32'hDEADBEEF);
    chk("dr_if_rd",   if_rdata, 32'h12345678);
    tick();
    chk("dr_idle_ack",  32'(d_ack), 32'd0);
    chk("dr_idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
